// File: rtl/pipe_stage_buffer_pkg.sv
// Shared constants and types for the pipeline stage registers of the five-stage CPU.
// Holds the stall-bit map and the per-cycle decision encoding.
package pipe_stage_buffer_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int SIGNAL_BUS = 64;

    typedef enum logic [2:0] {
        DEC_RESET   = 3'd0,
        DEC_FLUSH   = 3'd1,
        DEC_BUBBLE  = 3'd2,
        DEC_ADVANCE = 3'd3,
        DEC_HOLD    = 3'd4
    } stage_decision_e;

    // Priority: reset, flush, bubble (up && !dn), advance (!up), hold (up && dn).
    function automatic stage_decision_e pick_decision(
        input logic reset_i,
        input logic flush_i,
        input logic up_i,
        input logic dn_i
    );
        stage_decision_e dec;
        if (reset_i == ENABLE) begin
            dec = DEC_RESET;
        end else if (flush_i == ENABLE) begin
            dec = DEC_FLUSH;
        end else if ((up_i == ENABLE) && (dn_i == DISABLE)) begin
            dec = DEC_BUBBLE;
        end else if (up_i == DISABLE) begin
            dec = DEC_ADVANCE;
        end else begin
            dec = DEC_HOLD;
        end
        return dec;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating event counter: sticks at all-ones, clear beats increment, reset beats both.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // next-count selection: clear, saturating increment or keep
    always_comb begin
        count_d = count_q;
        if (clear == 1'b1) begin
            count_d = {WIDTH{1'b0}};
        end else if ((inc == 1'b1) && (count_q != COUNT_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with flush/bubble/advance/hold control, valid bit
// and saturating hold/bubble/flush performance counters.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH   = SIGNAL_BUS,
    parameter int                    STALL_WIDTH  = 6,
    parameter int                    STAGE        = STALL_IF,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [STALL_WIDTH-1:0] stall,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   clear_counters,
    output logic [COUNT_WIDTH-1:0] hold_count,
    output logic [COUNT_WIDTH-1:0] bubble_count,
    output logic [COUNT_WIDTH-1:0] flush_count
);

    localparam int DN_BIT = STAGE + 1;

    if ((STAGE < 0) || (DN_BIT >= STALL_WIDTH)) begin : g_bad_stage
        $fatal(1, "pipe_stage_buffer: STAGE+1 must be below STALL_WIDTH");
    end

    stage_decision_e       decision_s;
    logic                  up_s;
    logic                  dn_s;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_d;
    logic                  valid_q;
    logic                  hold_inc_s;
    logic                  bubble_inc_s;
    logic                  flush_inc_s;

    // per-cycle decision and next payload/valid
    always_comb begin
        up_s       = stall[STAGE];
        dn_s       = stall[DN_BIT];
        decision_s = pick_decision(reset, flush, up_s, dn_s);
        data_d     = data_q;
        valid_d    = valid_q;
        case (decision_s)
            DEC_RESET, DEC_FLUSH, DEC_BUBBLE: begin
                data_d  = BUBBLE_VALUE;
                valid_d = DISABLE;
            end
            DEC_ADVANCE: begin
                data_d  = in_data;
                valid_d = in_valid;
            end
            DEC_HOLD: begin
                data_d  = data_q;
                valid_d = valid_q;
            end
            default: begin
                data_d  = BUBBLE_VALUE;
                valid_d = DISABLE;
            end
        endcase
    end

    // Holds and flushes only count when they concern a real instruction.
    always_comb begin
        hold_inc_s   = (decision_s == DEC_HOLD)   && (valid_q == ENABLE);
        bubble_inc_s = (decision_s == DEC_BUBBLE);
        flush_inc_s  = (decision_s == DEC_FLUSH)  && (valid_q == ENABLE);
    end

    // payload and valid registers
    always_ff @(posedge clock) begin
        data_q  <= data_d;
        valid_q <= valid_d;
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_hold_counter (
        .clock (clock),
        .reset (reset),
        .clear (clear_counters),
        .inc   (hold_inc_s),
        .count (hold_count)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_bubble_counter (
        .clock (clock),
        .reset (reset),
        .clear (clear_counters),
        .inc   (bubble_inc_s),
        .count (bubble_count)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_counter (
        .clock (clock),
        .reset (reset),
        .clear (clear_counters),
        .inc   (flush_inc_s),
        .count (flush_count)
    );

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a default instance and a 3-bit-counter,
// non-zero-bubble instance share one stimulus stream.
module tb_pipe_stage_buffer;

    localparam logic [63:0] BV2   = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] PAY_A = 64'h0040_0000_3C01_0001;
    localparam logic [63:0] PAY_B = 64'h0040_0004_2402_0005;
    localparam logic [63:0] PAY_C = 64'h0040_0008_0000_0000;
    localparam logic [63:0] PAY_D = 64'h0040_000C_AC22_0010;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] in_data;
    logic        in_valid;
    logic        clear_counters;

    logic [63:0] out_data1, out_data2;
    logic        out_valid1, out_valid2;
    logic [15:0] hold1, bubble1, flush1;
    logic [2:0]  hold2, bubble2, flush2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipe_stage_buffer #(
        .DATA_WIDTH(64), .STALL_WIDTH(6), .STAGE(1),
        .BUBBLE_VALUE(64'h0), .COUNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data1), .out_valid(out_valid1),
        .clear_counters(clear_counters),
        .hold_count(hold1), .bubble_count(bubble1), .flush_count(flush1)
    );

    pipe_stage_buffer #(
        .DATA_WIDTH(64), .STALL_WIDTH(6), .STAGE(1),
        .BUBBLE_VALUE(BV2), .COUNT_WIDTH(3)
    ) dut_sat (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data2), .out_valid(out_valid2),
        .clear_counters(clear_counters),
        .hold_count(hold2), .bubble_count(bubble2), .flush_count(flush2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_counts(input string tag, input int h1, input int b1, input int f1,
                                input int h2, input int b2, input int f2);
        check_eq({tag, ".hold1"},   64'(hold1),   64'(h1));
        check_eq({tag, ".bubble1"}, 64'(bubble1), 64'(b1));
        check_eq({tag, ".flush1"},  64'(flush1),  64'(f1));
        check_eq({tag, ".hold2"},   64'(hold2),   64'(h2));
        check_eq({tag, ".bubble2"}, 64'(bubble2), 64'(b2));
        check_eq({tag, ".flush2"},  64'(flush2),  64'(f2));
    endtask

    task automatic check_out(input string tag, input logic [63:0] d1, input logic [63:0] d2,
                             input logic v);
        check_eq({tag, ".data1"},  out_data1,        d1);
        check_eq({tag, ".valid1"}, 64'(out_valid1),  64'(v));
        check_eq({tag, ".data2"},  out_data2,        d2);
        check_eq({tag, ".valid2"}, 64'(out_valid2),  64'(v));
    endtask

    initial begin
        reset = 1'b1; stall = 6'b000000; flush = 1'b0;
        in_data = 64'h0; in_valid = 1'b0; clear_counters = 1'b0;
        #2;
        step(2);
        check_out("reset", 64'h0, BV2, 1'b0);
        check_counts("reset", 0, 0, 0, 0, 0, 0);

        // advance
        reset = 1'b0; in_data = PAY_A; in_valid = 1'b1;
        step(1);
        check_out("advance", PAY_A, PAY_A, 1'b1);

        // hold three cycles while upstream payload keeps changing
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            in_data = 64'h1111_0000_0000_0000 + 64'(i);
            step(1);
        end
        check_out("hold", PAY_A, PAY_A, 1'b1);
        check_counts("hold", 3, 0, 0, 3, 0, 0);

        // bubble
        stall = 6'b000011;
        step(1);
        check_out("bubble", 64'h0, BV2, 1'b0);
        check_counts("bubble", 3, 1, 0, 3, 1, 0);

        // refill, then flush for two cycles over a full stall
        stall = 6'b000000; in_data = PAY_B; in_valid = 1'b1;
        step(1);
        check_out("refill", PAY_B, PAY_B, 1'b1);
        flush = 1'b1; stall = 6'b000111;
        step(2);
        check_out("flush", 64'h0, BV2, 1'b0);
        check_counts("flush", 3, 1, 1, 3, 1, 1);
        flush = 1'b0;

        // advance of an invalid payload, then a hold of it is not counted
        stall = 6'b000000; in_data = PAY_C; in_valid = 1'b0;
        step(1);
        check_out("adv_invalid", PAY_C, PAY_C, 1'b0);
        stall = 6'b000111;
        step(1);
        check_out("hold_invalid", PAY_C, PAY_C, 1'b0);
        check_counts("hold_invalid", 3, 1, 1, 3, 1, 1);

        // advance with downstream stalled but upstream free
        stall = 6'b000100; in_data = PAY_D; in_valid = 1'b1;
        step(1);
        check_out("adv_dn", PAY_D, PAY_D, 1'b1);

        // saturation of the 3-bit counter
        stall = 6'b000111; in_data = 64'h0;
        step(10);
        check_counts("saturate", 13, 1, 1, 7, 1, 1);

        // clear wins over increment, then counting resumes
        clear_counters = 1'b1;
        step(1);
        clear_counters = 1'b0;
        check_counts("clear", 0, 0, 0, 0, 0, 0);
        check_out("clear_keeps", PAY_D, PAY_D, 1'b1);
        step(1);
        check_counts("after_clear", 1, 0, 0, 1, 0, 0);

        // reset in the middle of a hold
        reset = 1'b1;
        step(1);
        check_out("reset_hold", 64'h0, BV2, 1'b0);
        check_counts("reset_hold", 0, 0, 0, 0, 0, 0);

        // reset in the middle of a flush
        reset = 1'b0; stall = 6'b000000; in_data = PAY_A; in_valid = 1'b1;
        step(1);
        reset = 1'b1; flush = 1'b1;
        step(1);
        check_out("reset_flush", 64'h0, BV2, 1'b0);
        check_counts("reset_flush", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised inter-stage pipeline register for the five-stage CPU, generalising the IF/ID latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it decides between reset, flush, bubble, advance and hold using the global stall vector and a flush request. It carries an explicit valid bit and keeps saturating performance counters of hold, bubble and flush cycles. It sits between two adjacent stages, with `stall` from the stall controller and `flush` from branch/exception logic.

## Interface
- `DATA_WIDTH`, default 64: width of the bundled stage payload (IF/ID: PC plus instruction).
- `STALL_WIDTH`, default 6: width of the global stall vector.
- `STAGE`, default 1: index of the upstream stall bit. `STAGE+1` is the downstream bit. Requires `STAGE+1 < STALL_WIDTH`.
- `BUBBLE_VALUE`, default 0: payload written on reset, flush and bubble.
- `COUNT_WIDTH`, default 16: width of each performance counter.

- `clock`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Synchronous, active-high.
- `stall`: input, `STALL_WIDTH` bits. Global stall vector; bit i set means stage i is stalled.
- `flush`: input, 1 bit. Discard the payload currently held.
- `in_data`: input, `DATA_WIDTH` bits. Upstream payload.
- `in_valid`: input, 1 bit. Upstream payload is a real instruction.
- `out_data`: output, `DATA_WIDTH` bits. Registered payload to the downstream stage.
- `out_valid`: output, 1 bit. Registered valid.
- `clear_counters`: input, 1 bit. Synchronous zeroing of all three counters.
- `hold_count`: output, `COUNT_WIDTH` bits. Number of cycles the register held a valid payload.
- `bubble_count`: output, `COUNT_WIDTH` bits. Number of bubbles inserted.
- `flush_count`: output, `COUNT_WIDTH` bits. Number of flushes that discarded a valid payload.

## Operation
Define `up = stall[STAGE]` and `dn = stall[STAGE+1]`. Rules are evaluated in strict priority order on each rising edge:
1. **reset**: `out_data` = `BUBBLE_VALUE`, `out_valid` = 0, all counters = 0.
2. **flush**: `out_data` = `BUBBLE_VALUE`, `out_valid` = 0. Flush overrides every stall combination. `flush_count` increments only if `out_valid` was 1.
3. **up && !dn (bubble)**: `out_data` = `BUBBLE_VALUE`, `out_valid` = 0. `bubble_count` increments.
4. **!up (advance)**: `out_data` = `in_data`, `out_valid` = `in_valid`. This applies even when `dn` is 1; a stall controller that keeps the stall vector monotonic never produces that combination.
5. **up && dn (hold)**: `out_data` and `out_valid` are unchanged. `hold_count` increments only if `out_valid` is 1.

Counters:
- Counters saturate at all-ones and never wrap.
- `clear_counters` has lower priority than `reset` and higher priority than increments. A clear and an increment in the same cycle leaves the counter at 0.
- The counters are independent of the payload path. `clear_counters` does not affect `out_data` or `out_valid`.

Implicit two-state view, derived from `out_valid` (no separate state register):
- **EMPTY** (`out_valid` = 0) goes to **FULL** on an advance with `in_valid` = 1.
- **FULL** goes to **EMPTY** on flush, on a bubble, or on an advance with `in_valid` = 0.

## Timing
- Latency is one cycle from input to output on an advance.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset takes effect on the first rising edge where `reset` = 1, including mid-stall and mid-flush. The outputs show reset values after that edge.
- A flush asserted for N consecutive cycles produces N bubble cycles, but increments `flush_count` at most once per valid payload discarded.
- Counters update on the same edge as the payload decision, so the count is visible the cycle after the event.
- `STALL_WIDTH` and `STAGE` are checked at elaboration; an illegal `STAGE` is a fatal elaboration error.

## Structure
- Shared package / `macro.v` holds:
  - the stall-bit index constants `STALL_PC`, `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`, `STALL_WB`;
  - the `ENABLE`/`DISABLE` constants;
  - the default `SIGNAL_BUS` width.
- One sub-module, `sat_counter` (parameters: width; inputs: clear, inc; output: count; saturating). It is instantiated three times.
- The payload register and the decision logic live in `pipe_stage_buffer` itself.

## Test plan
- **Reset**: with `DATA_WIDTH` = 64 and `BUBBLE_VALUE` = 0, assert reset for 2 cycles -> `out_data` = 0, `out_valid` = 0, all counters 0.
- **Advance and hold**: with `STAGE` = 1, `stall` = 6'b000000, `in_data` = 0x00400000_3C010001, `in_valid` = 1 -> the next cycle shows that payload with `out_valid` = 1. Then drive `stall` = 6'b000111 for 3 cycles while changing `in_data` -> the output holds the original payload and `hold_count` = 3.
- **Bubble**: with the register full, drive `stall` = 6'b000011 for 1 cycle -> `out_data` = 0, `out_valid` = 0, `bubble_count` = 1.
- **Flush priority**: with the register full, drive `flush` = 1 together with `stall` = 6'b000111 for 2 cycles -> bubble output, `flush_count` = 1 (not 2), `hold_count` unchanged.
- **Saturation**: with `COUNT_WIDTH` = 3, hold a valid payload for 10 cycles -> `hold_count` stays at 7. Then pulse `clear_counters` for 1 cycle while still holding -> 0 the next cycle, then 1.
- **Reset mid-hold**: with the register full and `stall` = 6'b000111, assert reset for 1 cycle -> `out_valid` = 0, `out_data` = `BUBBLE_VALUE`, counters 0.
